program_loader: RTL and testbench
=================================

# program_loader

Byte-stream writer for the processor's 32-bit program memory: the write-side counterpart of the instruction ROM read port. It accepts a framed byte stream (length, big-endian instruction words, XOR checksum) over a valid/ready interface. It assembles each group of four bytes into one opcode/operand word and writes the words to consecutive program-memory addresses from 0. While a load is in progress it holds the processor halted.

## Interface
Parameters:
- `DATA_WIDTH`, 16: address and half-word width; also the width of the length field and `words_loaded`.
- `ROM_WIDTH`, 32: program word width, {opcode[31:16], operand[15:0]}.
- `ROM_DEPTH`, 256: number of writable words; legal addresses are 0..ROM_DEPTH-1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load session.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte.
- `rom_write_enable`  out  1  one-cycle program-memory write strobe.
- `rom_write_addr`  out  DATA_WIDTH  word address.
- `rom_write_data`  out  ROM_WIDTH  word to write.
- `cpu_halt`  out  1  processor must not fetch while this is high.
- `load_busy`  out  1  session in progress.
- `load_done`  out  1  last session ended with a good checksum; sticky.
- `load_error`  out  1  last session failed; sticky.
- `words_loaded`  out  DATA_WIDTH  count of words written in the current or last session.

## Operation
- **Frame format:** LEN_HI, LEN_LO, then 4×LEN word bytes, then CHK.
  - LEN is a 16-bit word count.
  - Words are big-endian: the first byte of a word goes to [31:24], the last to [7:0].
  - CHK is the XOR of every preceding byte in the frame, including the LEN bytes.
- **Byte acceptance:** a byte is accepted on a rising edge where `rx_valid && rx_ready`. Bytes offered while `rx_ready`=0 are ignored, not queued.
- **FSM states:** IDLE, LEN_HI, LEN_LO, WORD, CHECK, DONE, ERROR.
  - **IDLE / DONE / ERROR:** `start` moves to LEN_HI. On that move: clear `load_done`, `load_error`, `words_loaded`, the checksum accumulator, the address counter and the byte index.
  - **LEN_HI:** accept a byte and go to LEN_LO.
  - **LEN_LO:** accept a byte. If LEN > ROM_DEPTH, go to ERROR. If LEN = 0, go to CHECK. Otherwise go to WORD.
  - **WORD:** a 2-bit byte index counts 0..3. On the fourth byte, issue a write, increment the address, and go to CHECK when the word count reaches LEN; otherwise stay in WORD with the index at 0.
  - **CHECK:** accept a byte. If it equals the accumulator, go to DONE; otherwise go to ERROR. The CHK byte is not itself XORed into the accumulator before the compare.
- **Outputs by state:**
  - `rx_ready` is 1 only in LEN_HI, LEN_LO, WORD and CHECK.
  - `load_busy` is 1 in the same states.
  - `cpu_halt` is 1 in LEN_HI..CHECK and in ERROR, and 0 in IDLE and DONE.
  - `load_done` is 1 in DONE; `load_error` is 1 in ERROR.
- **`start` while busy:** ignored.
- **Error behaviour:** words already written are not rolled back. The processor stays halted until a new `start` or `reset`.
- **Address arithmetic:** `rom_write_addr` runs 0..LEN-1. It cannot wrap, because LEN is bounded by ROM_DEPTH.
- **Write counting:** `words_loaded` increments in the same cycle as each `rom_write_enable` pulse.

## Timing
- **Reset values:** all outputs are 0, the FSM is in IDLE, and all internal registers are cleared. Reset mid-session aborts the session immediately; no further writes occur.
- **`start`:** `rx_ready` is high in the cycle after `start` is sampled.
- **Write latency:** `rom_write_enable`, `rom_write_addr` and `rom_write_data` are registered. They are valid for exactly one cycle, the cycle after the fourth byte of a word is accepted.
- **Throughput:** `rx_ready` does not drop during a write pulse, so the next byte may be accepted in the write-pulse cycle. Sustained rate is one byte per cycle.
- **Completion:** `load_done` or `load_error` rises, and `load_busy` falls, in the cycle after the CHK byte is accepted (or after LEN_LO, for an oversize LEN).
  - `cpu_halt` falls in that same cycle on success.
  - The last write pulse always precedes the `load_done` rise by at least one cycle.
- **Flag persistence:** `rom_write_data` holds its last value when idle. `load_done` and `load_error` persist until `start` or `reset`.

## Test plan
- **Good two-word frame:** start, then bytes 00 02 31 00 00 05 00 00 12 34 10, back-to-back.
  - Writes: addr 0 = 0x31000005, then addr 1 = 0x00001234.
  - `words_loaded`=2, `load_done`=1, `cpu_halt` falls one cycle after CHK, `load_error`=0.
- **Bad checksum:** the same frame with CHK=0x11.
  - Both writes still occur.
  - `load_error`=1, `cpu_halt` stays 1, `load_done`=0.
  - A following `start` clears the flags and `words_loaded`.
- **Oversize LEN:** start, then bytes 01 01 (LEN=257).
  - `load_error`=1 in the cycle after 0x01 is accepted; no write strobes.
  - `rx_ready`=0 thereafter.
- **Empty frame:** start, then bytes 00 00 00.
  - `load_done`=1, zero writes, `words_loaded`=0.
- **Valid gaps:** the good frame with random `rx_valid` gaps, plus `start` pulsed mid-frame and extra bytes offered while `rx_ready`=0.
  - Write pulses and values are identical to the back-to-back case.
  - The mid-frame `start` has no effect.
- **Reset mid-load:** `reset` asserted after 5 bytes of the good frame.
  - Next cycle: all outputs 0, FSM in IDLE, `rx_ready`=0.
  - Remaining bytes cause no writes.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: framed byte stream (LEN_HI, LEN_LO, 4*LEN big-endian word bytes, XOR CHK) to program-memory writes; ports: start/rx_* in, rom_write_* out, cpu_halt/load_busy/load_done/load_error/words_loaded status
module program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ROM_WIDTH  = 32,
  parameter int ROM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  rom_write_enable,
  output logic [DATA_WIDTH-1:0] rom_write_addr,
  output logic [ROM_WIDTH-1:0]  rom_write_data,
  output logic                  cpu_halt,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [DATA_WIDTH-1:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, WORD, CHECK, DONE, ERROR} state_t;
  localparam logic [DATA_WIDTH:0] DEPTH = ROM_DEPTH[DATA_WIDTH:0];
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d, waddr_q, waddr_d;
  logic [ROM_WIDTH-9:0]  buf_q, buf_d;
  logic [ROM_WIDTH-1:0]  wdata_q, wdata_d;
  logic [7:0]            chk_q, chk_d;
  logic [1:0]            idx_q, idx_d;
  logic                  we_q, we_d, rdy_q, halt_q, done_q, err_q, acc;
  assign acc = rx_valid && rdy_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d = LEN_HI;
        len_d   = '0;
        cnt_d   = '0;
        chk_d   = '0;
        idx_d   = '0;
      end
      LEN_HI: if (acc) begin
        state_d = LEN_LO;
        len_d   = {len_q[DATA_WIDTH-9:0], rx_data};
        chk_d   = chk_q ^ rx_data;
      end
      LEN_LO: if (acc) begin
        len_d   = {len_q[DATA_WIDTH-9:0], rx_data};
        chk_d   = chk_q ^ rx_data;
        state_d = ({1'b0, len_d} > DEPTH) ? ERROR : (len_d == '0) ? CHECK : WORD;
      end
      WORD: if (acc) begin
        chk_d = chk_q ^ rx_data;
        buf_d = {buf_q[ROM_WIDTH-17:0], rx_data};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = {buf_q, rx_data};
          cnt_d   = cnt_q + DATA_WIDTH'(1);
          state_d = (cnt_d == len_q) ? CHECK : WORD;
        end
      end
      CHECK: if (acc) state_d = (rx_data == chk_q) ? DONE : ERROR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdy_q   <= state_d inside {LEN_HI, LEN_LO, WORD, CHECK};
      halt_q  <= state_d inside {LEN_HI, LEN_LO, WORD, CHECK, ERROR};
      done_q  <= state_d == DONE;
      err_q   <= state_d == ERROR;
    end
  end
  assign rx_ready         = rdy_q;
  assign load_busy        = rdy_q;
  assign cpu_halt         = halt_q;
  assign load_done        = done_q;
  assign load_error       = err_q;
  assign rom_write_enable = we_q;
  assign rom_write_addr   = waddr_q;
  assign rom_write_data   = wdata_q;
  assign words_loaded     = cnt_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of framing, checksum, oversize, empty, gaps and reset abort
module tb_program_loader;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, rom_write_enable, cpu_halt, load_busy, load_done, load_error;
  logic [15:0] rom_write_addr, words_loaded;
  logic [31:0] rom_write_data;
  int          nerr = 0, nchk = 0, nw = 0;
  logic [15:0] wa [8];
  logic [31:0] wd [8];
  logic [15:0] wl [8];
  logic [7:0]  good [11] = '{8'h00, 8'h02, 8'h31, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h12, 8'h34, 8'h10};

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rom_write_enable(rom_write_enable), .rom_write_addr(rom_write_addr),
    .rom_write_data(rom_write_data), .cpu_halt(cpu_halt), .load_busy(load_busy),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rom_write_enable) begin
      if (nw < 8) begin
        wa[nw] = rom_write_addr;
        wd[nw] = rom_write_data;
        wl[nw] = words_loaded;
      end
      nw = nw + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_wait", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_good_writes(input string tag);
    chk({tag, "_nw"}, nw, 2);
    chk({tag, "_a0"}, wa[0], 0);
    chk({tag, "_d0"}, wd[0], 32'h3100_0005);
    chk({tag, "_wl0"}, wl[0], 1);
    chk({tag, "_a1"}, wa[1], 1);
    chk({tag, "_d1"}, wd[1], 32'h0000_1234);
    chk({tag, "_wl1"}, wl[1], 2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", rx_ready, 0);
    chk("rst_halt", cpu_halt, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    chk("rst_we", rom_write_enable, 0);
    chk("rst_words", words_loaded, 0);
    reset = 1'b0;
    @(negedge clk);

    pulse_start();
    chk("good_ready_after_start", rx_ready, 1);
    chk("good_halt_busy", {cpu_halt, load_busy}, 2'b11);
    nw = 0;
    for (int i = 0; i < 11; i++) send(good[i]);
    chk("good_done", load_done, 1);
    chk("good_err", load_error, 0);
    chk("good_halt", cpu_halt, 0);
    chk("good_busy", load_busy, 0);
    chk("good_words", words_loaded, 2);
    check_good_writes("good");
    chk("good_wdata_hold", rom_write_data, 32'h0000_1234);

    pulse_start();
    chk("bad_flags_cleared", {load_done, load_error}, 2'b00);
    chk("bad_words_cleared", words_loaded, 0);
    nw = 0;
    for (int i = 0; i < 10; i++) send(good[i]);
    send(8'h11);
    chk("bad_err", load_error, 1);
    chk("bad_done", load_done, 0);
    chk("bad_halt", cpu_halt, 1);
    chk("bad_ready", rx_ready, 0);
    chk("bad_nw", nw, 2);
    chk("bad_words", words_loaded, 2);

    pulse_start();
    chk("restart_err_cleared", load_error, 0);
    chk("restart_words_cleared", words_loaded, 0);
    nw = 0;
    send(8'h01);
    send(8'h01);
    chk("over_err", load_error, 1);
    chk("over_busy", load_busy, 0);
    chk("over_halt", cpu_halt, 1);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk("over_ready", rx_ready, 0);
    chk("over_nw", nw, 0);

    pulse_start();
    nw = 0;
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("empty_done", load_done, 1);
    chk("empty_err", load_error, 0);
    chk("empty_words", words_loaded, 0);
    chk("empty_nw", nw, 0);

    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk("idle_bytes_ignored", {load_done, load_busy}, 2'b10);
    pulse_start();
    nw = 0;
    for (int i = 0; i < 11; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 4) pulse_start();
      send(good[i]);
    end
    chk("gap_done", load_done, 1);
    chk("gap_words", words_loaded, 2);
    check_good_writes("gap");

    pulse_start();
    nw = 0;
    for (int i = 0; i < 5; i++) send(good[i]);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", rx_ready, 0);
    chk("mid_rst_halt", cpu_halt, 0);
    chk("mid_rst_busy", load_busy, 0);
    chk("mid_rst_flags", {load_done, load_error}, 2'b00);
    chk("mid_rst_words", words_loaded, 0);
    chk("mid_rst_addr", rom_write_addr, 0);
    chk("mid_rst_data", rom_write_data, 0);
    reset = 1'b0;
    for (int i = 5; i < 11; i++) begin
      rx_valid = 1'b1;
      rx_data  = good[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_nw", nw, 0);
    chk("mid_rst_idle_ready", rx_ready, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
